// File: rtl/ulpi_cfg_pkg.sv
// ulpi_cfg_pkg: shared state encoding, register-write type and PHY init table for the ULPI config sequencer
package ulpi_cfg_pkg;
    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_READY   = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;
    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } reg_write_t;
    localparam int INIT_LEN = 3;
    localparam int IDX_W = $clog2(INIT_LEN + 1);
    localparam logic [1:0] TXCMD_REG_WRITE = 2'b10;
    // Function Control, OTG Control, Interface Control
    function automatic reg_write_t init_entry(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(0) ? reg_write_t'({6'h04, 8'h48})
             : idx == IDX_W'(1) ? reg_write_t'({6'h0A, 8'h00})
             : reg_write_t'({6'h07, 8'h00});
    endfunction
endpackage

// File: rtl/ulpi_write_watchdog.sv
// ulpi_write_watchdog: per-attempt timeout, busy tracking and abort detection for one engine write
module ulpi_write_watchdog
    import ulpi_cfg_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic dir,
    input  logic wr_busy,
    output logic done,
    output logic fail,
    output logic eng_rst
);
    logic [7:0] tmo_cnt;
    logic busy_seen, aborted, complete, timeout;
    assign complete = active && busy_seen && !wr_busy;
    assign timeout = active && tmo_cnt == TIMEOUT_CYCLES;
    assign done = complete && !aborted;
    assign fail = (complete && aborted) || (timeout && !complete);
    // Attempt state clears outside WAIT; the counter preloads 1 there so it equals cycles since WR_START
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= 8'd0;
            busy_seen <= 1'b0;
            aborted <= 1'b0;
            eng_rst <= 1'b1;
        end else begin
            tmo_cnt <= !active ? 8'd1 : &tmo_cnt ? tmo_cnt : tmo_cnt + 8'd1;
            busy_seen <= active && (busy_seen || wr_busy);
            aborted <= active && (aborted || (dir && wr_busy));
            eng_rst <= timeout && !complete;
        end
    end
endmodule

// File: rtl/ulpi_cfg_sequencer.sv
// ulpi_cfg_sequencer: programs the PHY init table, then serialises host register writes to the ULPI write engine
module ulpi_cfg_sequencer
    import ulpi_cfg_pkg::*;
#(
    parameter logic [15:0] STARTUP_CYCLES = 16'd1000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64,
    parameter logic [1:0]  MAX_RETRY      = 2'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir,
    input  logic       host_req,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_data,
    output logic       host_ack,
    output logic       host_err,
    output logic       init_done,
    output logic       init_err,
    output logic       wr_start,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_busy,
    output logic       eng_rst
);
    state_t state;
    logic [15:0] startup_cnt;
    logic [1:0] retry;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [5:0] host_addr_q;
    logic [7:0] host_data_q;
    reg_write_t entry;
    logic wd_done, wd_fail;
    assign idx_nx = idx + 1'b1;
    assign entry = init_done ? reg_write_t'({host_addr_q, host_data_q}) : init_entry(idx);

    ulpi_write_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (state == ST_WAIT),
        .dir    (dir),
        .wr_busy(wr_busy),
        .done   (wd_done),
        .fail   (wd_fail),
        .eng_rst(eng_rst)
    );

    // Sequencer FSM; init_done doubles as the init/runtime phase flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_STARTUP;
            startup_cnt <= 16'd0;
            retry <= 2'd0;
            idx <= '0;
            host_addr_q <= 6'd0;
            host_data_q <= 8'd0;
            wr_start <= 1'b0;
            wr_addr <= 6'd0;
            wr_data <= 8'd0;
            host_ack <= 1'b0;
            host_err <= 1'b0;
            init_done <= 1'b0;
            init_err <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            host_ack <= 1'b0;
            host_err <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (startup_cnt == STARTUP_CYCLES - 16'd1) state <= ST_ISSUE;
                    else startup_cnt <= startup_cnt + 16'd1;
                end
                ST_ISSUE: begin
                    if (!dir) begin
                        wr_start <= 1'b1;
                        wr_addr <= entry.addr;
                        wr_data <= entry.data;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wd_done) begin
                        retry <= 2'd0;
                        if (init_done) begin
                            host_ack <= 1'b1;
                            state <= ST_READY;
                        end else begin
                            idx <= idx_nx;
                            init_done <= idx_nx == IDX_W'(INIT_LEN);
                            state <= idx_nx == IDX_W'(INIT_LEN) ? ST_READY : ST_ISSUE;
                        end
                    end else if (wd_fail) begin
                        if (retry < MAX_RETRY) begin
                            retry <= retry + 2'd1;
                            state <= ST_RECOVER;
                        end else begin
                            retry <= 2'd0;
                            host_ack <= init_done;
                            host_err <= init_done;
                            init_err <= !init_done;
                            state <= init_done ? ST_READY : ST_ERROR;
                        end
                    end
                end
                ST_RECOVER: state <= ST_ISSUE;
                ST_READY: begin
                    if (host_req && !dir) begin
                        host_addr_q <= host_addr;
                        host_data_q <= host_data;
                        state <= ST_ISSUE;
                    end
                end
                ST_ERROR: state <= ST_ERROR;
                default: state <= ST_ERROR;
            endcase
        end
    end
endmodule
